// File: rtl/visor_pkg.sv
// Shared definitions for the visor target-control block: register map,
// tg_ctrl/status bit positions and FSM state encoding.
package visor_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned NUM_BP = 4;
   localparam int unsigned ST_W   = 2;

   localparam logic [REG_AW-1:0] REG_BP0      = 3'd0;
   localparam logic [REG_AW-1:0] REG_BP1      = 3'd1;
   localparam logic [REG_AW-1:0] REG_BP2      = 3'd2;
   localparam logic [REG_AW-1:0] REG_BP3      = 3'd3;
   localparam logic [REG_AW-1:0] REG_TG_CTRL  = 3'd4;
   localparam logic [REG_AW-1:0] REG_TG_CODE  = 3'd5;
   localparam logic [REG_AW-1:0] REG_STATUS   = 3'd6;
   localparam logic [REG_AW-1:0] REG_HIT_ADDR = 3'd7;

   localparam int unsigned TG_RESET_BIT   = 15;
   localparam int unsigned DIVERT_BIT     = 14;
   localparam int unsigned CODE_READY_BIT = 13;
   localparam int unsigned RESUME_BIT     = 0;
   localparam int unsigned STEP_BIT       = 1;

   localparam int unsigned STATUS_HALT_BIT = 8;
   localparam int unsigned STATUS_INJ_BIT  = 9;

   localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
   localparam logic [ST_W-1:0] ST_HALT   = 2'd1;
   localparam logic [ST_W-1:0] ST_INJECT = 2'd2;

   // Readback image of tg_ctrl; pulse bits always read 0.
   function automatic logic [DATA_W-1:0] ctrl_word(input logic rst, input logic divert,
                                                   input logic ready);
      logic [DATA_W-1:0] w;
      w                 = '0;
      w[TG_RESET_BIT]   = rst;
      w[DIVERT_BIT]     = divert;
      w[CODE_READY_BIT] = ready;
      return w;
   endfunction

endpackage

// File: rtl/visor_target_ctrl_if.sv
// Visor register bus: one-cycle write strobe plus combinational read-back.
interface visor_target_ctrl_if;
   import visor_pkg::*;

   logic              reg_wr_en;
   logic [REG_AW-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wr_data;
   logic [DATA_W-1:0] reg_rd_data;

   modport master (
      output reg_wr_en,
      output reg_addr,
      output reg_wr_data,
      input  reg_rd_data
   );

   modport slave (
      input  reg_wr_en,
      input  reg_addr,
      input  reg_wr_data,
      output reg_rd_data
   );

endinterface

// File: rtl/visor_bp_match.sv
// Four-way breakpoint comparator; an entry equal to BP_DISABLED never matches.
module visor_bp_match
   import visor_pkg::*;
#(
   parameter logic [DATA_W-1:0] BP_DISABLED = 16'hffff
) (
   input  logic                           fetch,
   input  logic [DATA_W-1:0]              fetch_addr,
   input  logic [NUM_BP-1:0][DATA_W-1:0]  bp_addr,
   output logic [NUM_BP-1:0]              match
);

   always_comb begin
      match = '0;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
         match[i] = fetch && (bp_addr[i] != BP_DISABLED) && (fetch_addr == bp_addr[i]);
      end
   end

endmodule

// File: rtl/visor_target_ctrl.sv
// Visor-driven target control: reset hold, breakpoint halt and code-bus injection.
// Optional single-step via tg_ctrl[1] when VISOR_SINGLE_STEP_EN is defined.
module visor_target_ctrl
   import visor_pkg::*;
#(
   parameter logic [DATA_W-1:0] BP_DISABLED = 16'hffff
) (
   input  logic                sysclk,
   input  logic                sysreset,
   visor_target_ctrl_if.slave  reg_bus,
   input  logic                tg_fetch,
   input  logic [DATA_W-1:0]   tg_fetch_addr,
   input  logic [DATA_W-1:0]   tg_rom_data,
   output logic [DATA_W-1:0]   tg_code,
   output logic                tg_hold,
   output logic                tg_reset
);

   logic [NUM_BP-1:0][DATA_W-1:0] bp_q, bp_d;
   logic [ST_W-1:0]               state_q, state_d;
   logic [DATA_W-1:0]             hit_addr_q, hit_addr_d;
   logic [DATA_W-1:0]             code_q, code_d;
   logic [NUM_BP-1:0]             mask_q, mask_d;
   logic                          rst_bit_q, rst_bit_d;
   logic                          divert_q, divert_d;
   logic                          ready_q, ready_d;
   logic                          suppress_q, suppress_d;
`ifdef VISOR_SINGLE_STEP_EN
   logic                          step_q, step_d;
   logic                          step_req;
`endif

   logic [NUM_BP-1:0] match_raw;
   logic [NUM_BP-1:0] match;
   logic              bp_hit;
   logic              wr_ctrl;
   logic              wr_code;
   logic              resume_req;

   visor_bp_match #(.BP_DISABLED(BP_DISABLED)) u_bp_match (
      .fetch      (tg_fetch),
      .fetch_addr (tg_fetch_addr),
      .bp_addr    (bp_q),
      .match      (match_raw)
   );

   // The address we just halted on is skipped once so resume can refetch it.
   always_comb begin
      match = match_raw;
      if (suppress_q && (tg_fetch_addr == hit_addr_q)) match = '0;
      bp_hit = (state_q == ST_RUN) && !rst_bit_q && (|match);
   end

   assign wr_ctrl    = reg_bus.reg_wr_en && (reg_bus.reg_addr == REG_TG_CTRL);
   assign wr_code    = reg_bus.reg_wr_en && (reg_bus.reg_addr == REG_TG_CODE);
   assign resume_req = wr_ctrl && reg_bus.reg_wr_data[RESUME_BIT];
`ifdef VISOR_SINGLE_STEP_EN
   assign step_req   = wr_ctrl && reg_bus.reg_wr_data[STEP_BIT];
`endif

   // Target-facing outputs: hold is combinational so a breakpoint stalls its own fetch.
   always_comb begin
      tg_reset = rst_bit_q;
      tg_code  = (state_q == ST_INJECT) ? code_q : tg_rom_data;
      tg_hold  = 1'b0;
      if (!rst_bit_q) begin
         case (state_q)
            ST_RUN:  tg_hold = bp_hit;
            ST_HALT: tg_hold = 1'b1;
            default: tg_hold = 1'b0;
         endcase
      end
   end

   always_comb begin
      reg_bus.reg_rd_data = '0;
      case (reg_bus.reg_addr)
         REG_BP0, REG_BP1, REG_BP2, REG_BP3:
            reg_bus.reg_rd_data = bp_q[reg_bus.reg_addr[1:0]];
         REG_TG_CTRL:  reg_bus.reg_rd_data = ctrl_word(rst_bit_q, divert_q, ready_q);
         REG_TG_CODE:  reg_bus.reg_rd_data = code_q;
         REG_STATUS: begin
            reg_bus.reg_rd_data[NUM_BP-1:0]      = mask_q;
            reg_bus.reg_rd_data[STATUS_HALT_BIT] = (state_q == ST_HALT);
            reg_bus.reg_rd_data[STATUS_INJ_BIT]  = (state_q == ST_INJECT);
         end
         default:      reg_bus.reg_rd_data = hit_addr_q;
      endcase
   end

   // Next-state: register writes, FSM transitions, then tg_reset override.
   always_comb begin
      bp_d       = bp_q;
      state_d    = state_q;
      hit_addr_d = hit_addr_q;
      code_d     = code_q;
      mask_d     = mask_q;
      rst_bit_d  = rst_bit_q;
      divert_d   = divert_q;
      ready_d    = ready_q;
      suppress_d = suppress_q;
`ifdef VISOR_SINGLE_STEP_EN
      step_d     = step_q;
`endif

      for (int unsigned i = 0; i < NUM_BP; i++) begin
         if (reg_bus.reg_wr_en && (reg_bus.reg_addr == REG_AW'(i))) bp_d[i] = reg_bus.reg_wr_data;
      end
      if (wr_ctrl) begin
         rst_bit_d = reg_bus.reg_wr_data[TG_RESET_BIT];
         divert_d  = reg_bus.reg_wr_data[DIVERT_BIT];
      end
      if (wr_code) code_d = reg_bus.reg_wr_data;

      case (state_q)
         ST_RUN: begin
            if (tg_fetch && (tg_fetch_addr != hit_addr_q)) suppress_d = 1'b0;
            if (bp_hit) begin
               state_d    = ST_HALT;
               hit_addr_d = tg_fetch_addr;
               mask_d     = match;
`ifdef VISOR_SINGLE_STEP_EN
               step_d     = 1'b0;
            end else if (step_q && tg_fetch) begin
               state_d    = ST_HALT;
               hit_addr_d = tg_fetch_addr;
               mask_d     = '0;
               step_d     = 1'b0;
`endif
            end
         end
         ST_HALT: begin
            if (resume_req) begin
               state_d    = ST_RUN;
               mask_d     = '0;
               suppress_d = 1'b1;
`ifdef VISOR_SINGLE_STEP_EN
            end else if (step_req) begin
               state_d    = ST_RUN;
               mask_d     = '0;
               suppress_d = 1'b1;
               step_d     = 1'b1;
`endif
            end else if (wr_code && divert_q) begin
               state_d = ST_INJECT;
               ready_d = 1'b1;
            end
         end
         ST_INJECT: begin
            if (tg_fetch) begin
               state_d = ST_HALT;
               ready_d = 1'b0;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (rst_bit_d) begin
         state_d    = ST_RUN;
         mask_d     = '0;
         suppress_d = 1'b0;
         ready_d    = 1'b0;
`ifdef VISOR_SINGLE_STEP_EN
         step_d     = 1'b0;
`endif
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         bp_q       <= {NUM_BP{BP_DISABLED}};
         state_q    <= ST_RUN;
         hit_addr_q <= '0;
         code_q     <= '0;
         mask_q     <= '0;
         rst_bit_q  <= 1'b1;
         divert_q   <= 1'b0;
         ready_q    <= 1'b0;
         suppress_q <= 1'b0;
`ifdef VISOR_SINGLE_STEP_EN
         step_q     <= 1'b0;
`endif
      end else begin
         bp_q       <= bp_d;
         state_q    <= state_d;
         hit_addr_q <= hit_addr_d;
         code_q     <= code_d;
         mask_q     <= mask_d;
         rst_bit_q  <= rst_bit_d;
         divert_q   <= divert_d;
         ready_q    <= ready_d;
         suppress_q <= suppress_d;
`ifdef VISOR_SINGLE_STEP_EN
         step_q     <= step_d;
`endif
      end
   end

endmodule
